// File: rtl/debounce_pkg.sv
// Shared types and constants for the input debounce block.
// Its only user is input_debounce.
package debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW     = 2'd0,
        S_PEND_HI = 2'd1,
        S_HIGH    = 2'd2,
        S_PEND_LO = 2'd3
    } deb_state_t;

    localparam int GLITCH_CNT_W        = 8;
    localparam int DEBOUNCE_CYCLES_DEF = 16;

endpackage

// File: rtl/bit_sync.sv
// STAGES-deep single-bit synchronizer with asynchronous active-high reset.
// The flops are chained directly, with no logic between stages.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) chain <= '0;
        else       chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/input_debounce.sv
// Synchronizes one raw async input and debounces it with a 4-state hold FSM.
// Optional DEBOUNCE_GLITCH_CNT_EN adds an 8-bit saturating aborted-transition counter.
module input_debounce
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic clean_out,
    output logic pending
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [GLITCH_CNT_W-1:0] glitch_cnt
`endif
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q;
    deb_state_t       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             abort;

    bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (raw_in),
        .q     (sync_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_LOW;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Counter only advances while qualifying; it resets on any settle or abort,
    // so every new transition starts a fresh window.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        abort   = 1'b0;
        case (state)
            S_LOW: begin
                if (sync_q) begin
                    state_d = S_PEND_HI;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            S_PEND_HI: begin
                if (!sync_q) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                    abort   = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (!sync_q) begin
                    state_d = S_PEND_LO;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            S_PEND_LO: begin
                if (sync_q) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                    abort   = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decode straight from the state flops so they never glitch.
    assign clean_out = (state == S_HIGH) || (state == S_PEND_LO);
    assign pending   = (state == S_PEND_HI) || (state == S_PEND_LO);

`ifdef DEBOUNCE_GLITCH_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                      glitch_cnt <= '0;
        else if (abort && ~&glitch_cnt) glitch_cnt <= glitch_cnt + GLITCH_CNT_W'(1);
    end
`else
    logic unused_abort;
    assign unused_abort = abort;
`endif

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// A per-cycle vector table covers clean, glitch, boundary and bounce; reset cases are hand-written.
module tb_input_debounce;

    logic clk = 1'b0;
    logic reset;
    logic raw_in;
    logic clean_out;
    logic pending;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;
`endif

    int total = 0;
    int bad   = 0;

    input_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .raw_in    (raw_in),
        .clean_out (clean_out),
        .pending   (pending)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_cnt(glitch_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic raw;
        logic clean;
        logic pend;
        int   glitch;
    } vec_t;

    vec_t vecs[$];

    task automatic push(input logic r, input logic c, input logic p, input int g);
        vec_t v;
        v.raw = r; v.clean = c; v.pend = p; v.glitch = g;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int e;
        int gb;

        // Row j applies raw after edge j; the check is taken after edge e=j+1.
        // Clean rise then clean fall.
        for (int j = 0; j < 20; j++) begin
            e = j + 1;
            push(j < 10, e >= 6 && e <= 15, (e >= 3 && e <= 5) || (e >= 13 && e <= 15), 0);
        end
        // Three-cycle glitch aborts at edge 6.
        for (int j = 0; j < 10; j++) begin
            e = j + 1;
            push(j < 3, 1'b0, e >= 3 && e <= 5, (e >= 6) ? 1 : 0);
        end
        gb = 1;
        // Exactly four cycles high: propagates as a four-cycle clean pulse.
        for (int j = 0; j < 12; j++) begin
            e = j + 1;
            push(j < 4, e >= 6 && e <= 9, (e >= 3 && e <= 5) || (e >= 7 && e <= 9), gb);
        end
        // Bounce 1,0,1,0 then hold 1, later release to 0.
        for (int j = 0; j < 24; j++) begin
            e = j + 1;
            push((j == 0 || j == 2 || (j >= 4 && j < 14)), e >= 10 && e <= 19,
                 e == 3 || e == 5 || (e >= 7 && e <= 9) || (e >= 17 && e <= 19),
                 gb + ((e >= 4) ? 1 : 0) + ((e >= 6) ? 1 : 0));
        end

        // Reset held with raw high.
        reset  = 1'b1;
        raw_in = 1'b1;
        repeat (3) step();
        chk("rst_clean", clean_out, 0);
        chk("rst_pend", pending, 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        chk("rst_glitch", glitch_cnt, 0);
`endif
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("rel_clean_e%0d", k), clean_out, (k >= 6) ? 1 : 0);
            chk($sformatf("rel_pend_e%0d", k), pending, (k >= 3 && k <= 5) ? 1 : 0);
        end
        raw_in = 1'b0;
        repeat (10) step();
        chk("rel_settle_low", clean_out, 0);

        foreach (vecs[i]) begin
            raw_in = vecs[i].raw;
            step();
            chk($sformatf("tbl%0d_clean", i), clean_out, vecs[i].clean);
            chk($sformatf("tbl%0d_pend", i), pending, vecs[i].pend);
`ifdef DEBOUNCE_GLITCH_CNT_EN
            chk($sformatf("tbl%0d_glitch", i), glitch_cnt, vecs[i].glitch);
`endif
        end

        // Reset while qualifying a fall in S_PEND_LO.
        raw_in = 1'b1;
        repeat (10) step();
        chk("mid_high", clean_out, 1);
        raw_in = 1'b0;
        repeat (3) step();
        chk("mid_pend", pending, 1);
        chk("mid_clean", clean_out, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_async_clean", clean_out, 0);
        chk("mid_async_pend", pending, 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        chk("mid_glitch_clr", glitch_cnt, 0);
`endif
        step();
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk($sformatf("post_clean_%0d", k), clean_out, 0);
            chk($sformatf("post_pend_%0d", k), pending, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
